edge_detect_multi: RTL and testbench

- Parametrised, multi-channel successor to the single-line d_plus edge detector.
- Each channel synchronises an asynchronous input, applies a programmable glitch filter and emits a one-cycle pulse on rising, falling or both edges, selected per channel.
- Each channel also keeps a sticky edge flag that software clears.
- Sits between the USB/serial pads and the receiver FSMs.

---
 rtl/edge_detect_pkg.sv | 30 +++
 rtl/edge_chan.sv | 86 ++++++++
 rtl/edge_detect_multi.sv | 44 ++++
 tb/tb_edge_detect_multi.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/edge_detect_pkg.sv
// Shared types and default parameters for the multi-channel edge detector.
// EDGE_COUNT_EN (optional macro) enables the per-channel saturating edge counters.
package edge_detect_pkg;

  typedef enum logic [1:0] {
    EDGE_OFF  = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_t;

  localparam int   DEF_NUM_CH      = 4;
  localparam int   DEF_SYNC_STAGES = 2;
  localparam int   DEF_FILT_W      = 3;
  localparam logic DEF_IDLE_LEVEL  = 1'b1;
  localparam int   DEF_CNT_W       = 8;

  // new_lvl is the level the channel is about to take, so 1 means a rising transition
  function automatic logic edge_match(input edge_mode_t mode, input logic new_lvl);
    logic m;
    case (mode)
      EDGE_RISE: m = new_lvl;
      EDGE_FALL: m = ~new_lvl;
      EDGE_BOTH: m = 1'b1;
      default:   m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/edge_chan.sv
// One channel: synchroniser, glitch filter, edge detector, sticky flag and,
// when EDGE_COUNT_EN is defined, a saturating edge counter.
module edge_chan
  import edge_detect_pkg::*;
#(
  parameter int   SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int   FILT_W      = DEF_FILT_W,
  parameter logic IDLE_LEVEL  = DEF_IDLE_LEVEL,
  parameter int   CNT_W       = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              d_i,
  input  edge_mode_t        mode_i,
  input  logic [FILT_W-1:0] filt_len_i,
  input  logic              clr_i,
  output logic              edge_o,
  output logic              level_o,
  output logic              sticky_o,
  output logic [CNT_W-1:0]  cnt_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [FILT_W-1:0]      fcnt_q, fcnt_d;
  logic                   level_q, level_d;
  logic                   edge_q, edge_d;
  logic                   sticky_q, sticky_d;
  logic                   s;
  logic                   flip;

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], d_i};
    s       = sync_q[SYNC_STAGES-1];
    // >= keeps a mid-count drop of filt_len from running the counter past its limit
    flip    = (s != level_q) && (fcnt_q >= filt_len_i);
    level_d = level_q;
    fcnt_d  = '0;
    if (s != level_q) begin
      if (flip) level_d = s;
      else      fcnt_d  = fcnt_q + 1'b1;
    end
    edge_d   = flip & edge_match(mode_i, s);
    sticky_d = edge_d | (sticky_q & ~clr_i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q   <= {SYNC_STAGES{IDLE_LEVEL}};
      fcnt_q   <= '0;
      level_q  <= IDLE_LEVEL;
      edge_q   <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      fcnt_q   <= fcnt_d;
      level_q  <= level_d;
      edge_q   <= edge_d;
      sticky_q <= sticky_d;
    end
  end

  assign edge_o   = edge_q;
  assign level_o  = level_q;
  assign sticky_o = sticky_q;

`ifdef EDGE_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // clear takes priority but still counts an edge arriving on the same cycle
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                         cnt_d = CNT_W'(edge_d);
    else if (edge_d && (cnt_q != '1))  cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
`else
  assign cnt_o = '0;
`endif

endmodule

// File: rtl/edge_detect_multi.sv
// Multi-channel filtered edge detector between the pads and the receiver FSMs.
// Define EDGE_COUNT_EN to enable the per-channel edge counters on edge_cnt.
module edge_detect_multi
  import edge_detect_pkg::*;
#(
  parameter int   NUM_CH      = DEF_NUM_CH,
  parameter int   SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int   FILT_W      = DEF_FILT_W,
  parameter logic IDLE_LEVEL  = DEF_IDLE_LEVEL,
  parameter int   CNT_W       = DEF_CNT_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       d_in,
  input  logic [2*NUM_CH-1:0]     mode,
  input  logic [FILT_W-1:0]       filt_len,
  input  logic [NUM_CH-1:0]       clr,
  output logic [NUM_CH-1:0]       d_edge,
  output logic [NUM_CH-1:0]       d_level,
  output logic [NUM_CH-1:0]       edge_sticky,
  output logic [NUM_CH*CNT_W-1:0] edge_cnt
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    edge_chan #(
      .SYNC_STAGES(SYNC_STAGES),
      .FILT_W     (FILT_W),
      .IDLE_LEVEL (IDLE_LEVEL),
      .CNT_W      (CNT_W)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .d_i       (d_in[i]),
      .mode_i    (edge_mode_t'(mode[2*i +: 2])),
      .filt_len_i(filt_len),
      .clr_i     (clr[i]),
      .edge_o    (d_edge[i]),
      .level_o   (d_level[i]),
      .sticky_o  (edge_sticky[i]),
      .cnt_o     (edge_cnt[i*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_edge_detect_multi.sv
// Directed bench for edge_detect_multi: table of per-cycle vectors plus
// hand-written reset, latency, glitch-filter and counter sequences.
module tb_edge_detect_multi;
  import edge_detect_pkg::*;

  localparam int NUM_CH = 4;
  localparam int FILT_W = 3;
`ifdef EDGE_COUNT_EN
  localparam int CNT_W  = 2;
`else
  localparam int CNT_W  = 8;
`endif

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NUM_CH-1:0]       d_in;
  logic [2*NUM_CH-1:0]     mode;
  logic [FILT_W-1:0]       filt_len;
  logic [NUM_CH-1:0]       clr;
  logic [NUM_CH-1:0]       d_edge;
  logic [NUM_CH-1:0]       d_level;
  logic [NUM_CH-1:0]       edge_sticky;
  logic [NUM_CH*CNT_W-1:0] edge_cnt;

  edge_detect_multi #(
    .NUM_CH(NUM_CH), .SYNC_STAGES(2), .FILT_W(FILT_W), .IDLE_LEVEL(1'b1), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .d_in(d_in), .mode(mode), .filt_len(filt_len), .clr(clr),
    .d_edge(d_edge), .d_level(d_level), .edge_sticky(edge_sticky), .edge_cnt(edge_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] din;
    logic [7:0] md;
    logic [2:0] flen;
    logic [3:0] cl;
    logic [3:0] e_edge;
    logic [3:0] e_level;
    logic [3:0] e_sticky;
  } vec_t;

  vec_t tbl[12];
  int   n_vec = 0;
  int   n_err = 0;
  int   pulses[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; d_in = 4'b1111; mode = 8'h00; filt_len = 3'd0; clr = 4'b0000;
    #2;
    chk("reset_level",  32'(d_level),     32'hF);
    chk("reset_edge",   32'(d_edge),      32'h0);
    chk("reset_sticky", 32'(edge_sticky), 32'h0);
    chk("reset_cnt",    32'(edge_cnt),    32'h0);
    do_reset();

    // ch0..3 = OFF/RISE/FALL/BOTH, fall then rise, then sticky set/clear on ch3
    tbl[0]  = '{4'b0000, 8'hE4, 3'd0, 4'b0000, 4'b0000, 4'b1111, 4'b0000};
    tbl[1]  = '{4'b0000, 8'hE4, 3'd0, 4'b0000, 4'b0000, 4'b1111, 4'b0000};
    tbl[2]  = '{4'b0000, 8'hE4, 3'd0, 4'b0000, 4'b1100, 4'b0000, 4'b1100};
    tbl[3]  = '{4'b1111, 8'hE4, 3'd0, 4'b0000, 4'b0000, 4'b0000, 4'b1100};
    tbl[4]  = '{4'b1111, 8'hE4, 3'd0, 4'b0000, 4'b0000, 4'b0000, 4'b1100};
    tbl[5]  = '{4'b1111, 8'hE4, 3'd0, 4'b0000, 4'b1010, 4'b1111, 4'b1110};
    tbl[6]  = '{4'b1111, 8'hE4, 3'd0, 4'b0000, 4'b0000, 4'b1111, 4'b1110};
    tbl[7]  = '{4'b0111, 8'hE4, 3'd0, 4'b0000, 4'b0000, 4'b1111, 4'b1110};
    tbl[8]  = '{4'b0111, 8'hE4, 3'd0, 4'b0000, 4'b0000, 4'b1111, 4'b1110};
    tbl[9]  = '{4'b0111, 8'hE4, 3'd0, 4'b1000, 4'b1000, 4'b0111, 4'b1110};
    tbl[10] = '{4'b0111, 8'hE4, 3'd0, 4'b1000, 4'b0000, 4'b0111, 4'b0110};
    tbl[11] = '{4'b0111, 8'hE4, 3'd0, 4'b0110, 4'b0000, 4'b0111, 4'b0000};

    for (int c = 0; c < 4; c++) pulses[c] = 0;
    for (int r = 0; r < 12; r++) begin
      d_in = tbl[r].din; mode = tbl[r].md; filt_len = tbl[r].flen; clr = tbl[r].cl;
      tick();
      chk($sformatf("tbl%0d_edge", r),   32'(d_edge),      32'(tbl[r].e_edge));
      chk($sformatf("tbl%0d_level", r),  32'(d_level),     32'(tbl[r].e_level));
      chk($sformatf("tbl%0d_sticky", r), 32'(edge_sticky), 32'(tbl[r].e_sticky));
      if (r <= 6)
        for (int c = 0; c < 4; c++) pulses[c] += int'(d_edge[c]);
    end
    clr = 4'b0000;
    chk("mode_pulses_ch0", 32'(pulses[0]), 32'd0);
    chk("mode_pulses_ch1", 32'(pulses[1]), 32'd1);
    chk("mode_pulses_ch2", 32'(pulses[2]), 32'd1);
    chk("mode_pulses_ch3", 32'(pulses[3]), 32'd2);

    // reset asserted mid-count must act without waiting for a clock edge
    d_in = 4'b0110; filt_len = 3'd3;
    for (int k = 0; k < 4; k++) tick();
    chk("midcount_level", 32'(d_level), 32'h7);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_level",  32'(d_level),     32'hF);
    chk("async_rst_edge",   32'(d_edge),      32'h0);
    chk("async_rst_sticky", 32'(edge_sticky), 32'h0);
    d_in = 4'b1111;
    tick();
    rst = 1'b0;

    // basic rise on ch0, filt_len=0: pulse only on edge 3 after the 0->1 change
    do_reset();
    mode = 8'h01; filt_len = 3'd0; d_in = 4'b1110;
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk($sformatf("rise_fall_phase%0d", k), 32'({d_edge[0], d_level[0]}),
          32'({1'b0, (k < 3)}));
    end
    d_in = 4'b1111;
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk($sformatf("rise_rise_phase%0d", k), 32'({d_edge[0], d_level[0]}),
          32'({(k == 3), (k >= 3)}));
    end

    // filt_len=3 on ch1 in BOTH: 3-cycle glitch rejected
    do_reset();
    mode = 8'h0C; filt_len = 3'd3; d_in = 4'b1101;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 3) d_in = 4'b1111;
      chk($sformatf("glitch%0d", k), 32'({d_edge, d_level}), 32'({4'b0000, 4'b1111}));
    end
    // 4-cycle low: fall pulse on edge 6, return pulse on edge 10
    d_in = 4'b1101;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (k == 4) d_in = 4'b1111;
      chk($sformatf("pulse4_%0d", k), 32'({d_edge, d_level}),
          32'({2'b00, (k == 6 || k == 10), 1'b0, 2'b11, !(k >= 6 && k < 10), 1'b1}));
    end

`ifdef EDGE_COUNT_EN
    // CNT_W=2 saturates at 3; clr together with an edge leaves 1
    do_reset();
    mode = 8'h30; filt_len = 3'd0; d_in = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      d_in[2] = ~d_in[2];
      for (int k = 0; k < 4; k++) tick();
    end
    chk("cnt_saturate", 32'(edge_cnt[2*CNT_W +: CNT_W]), 32'd3);
    d_in[2] = ~d_in[2];
    tick();
    tick();
    clr = 4'b0100;
    tick();
    clr = 4'b0000;
    chk("cnt_clr_edge_pulse", 32'(d_edge[2]), 32'd1);
    chk("cnt_clr_with_edge",  32'(edge_cnt[2*CNT_W +: CNT_W]), 32'd1);
`else
    chk("cnt_disabled_zero", 32'(edge_cnt), 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
